slurm16_reset_sequencer: RTL and testbench

//  Reset/boot sequencer between the PLL and the slurm16 core on iCE40 builds. Holds the core in reset until
//  PLL lock has been stable for a programmable period. Re-resets the core on lock loss or a software request.

---
 rtl/slurm16_reset_sequencer_pkg.sv | 21 ++
 rtl/slurm16_sync2.sv | 25 ++
 rtl/slurm16_reset_sequencer.sv | 150 +++++++++++++++
 tb/tb_slurm16_reset_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/slurm16_reset_sequencer_pkg.sv
// Shared encodings for the slurm16 reset sequencer: FSM state codes, reset-cause
// codes and a saturating increment for the reset counter.
package slurm16_reset_sequencer_pkg;

   localparam logic [2:0] S_RESET     = 3'd0;
   localparam logic [2:0] S_WAIT_LOCK = 3'd1;
   localparam logic [2:0] S_STABLE    = 3'd2;
   localparam logic [2:0] S_RUN       = 3'd3;
   localparam logic [2:0] S_HOLD      = 3'd4;

   localparam logic [1:0] CAUSE_POR       = 2'd0;
   localparam logic [1:0] CAUSE_LOCK_LOSS = 2'd1;
   localparam logic [1:0] CAUSE_SOFT      = 2'd2;
   localparam logic [1:0] CAUSE_WDT       = 2'd3;

   // Reset counter sticks at 255 rather than wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/slurm16_sync2.sv
// Generic 2-flop synchronizer with synchronous active-high reset.
module slurm16_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   // Two back-to-back flops; only sync_q is safe to use in the clk domain.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/slurm16_reset_sequencer.sv
// Reset/boot sequencer between the PLL and the slurm16 core. Holds the core in
// reset until PLL lock has been stable long enough, re-resets on lock loss, soft
// request or watchdog, and records last cause plus a saturating reset count.
// Optional watchdog: define SLURM16_RSTSEQ_WDT_EN to build it.
module slurm16_reset_sequencer
   import slurm16_reset_sequencer_pkg::*;
#(
   parameter int unsigned LOCK_STABLE_CYCLES = 10000,
   parameter int unsigned HOLD_CYCLES        = 16,
   parameter int unsigned WDT_CYCLES         = 25125000,
   parameter int unsigned CNT_W              = 25
) (
   input  logic       clk,
   input  logic       RST,
   input  logic       pll_locked,
   input  logic       soft_reset_req,
   input  logic       wdt_kick,
   output logic       cpu_RSTb,
   output logic [2:0] state,
   output logic [1:0] rst_cause,
   output logic [7:0] reset_count
);

   localparam logic [CNT_W-1:0] StableLast = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HoldLast   = CNT_W'(HOLD_CYCLES - 1);

   logic             lock_s;
   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       cause_q, cause_d;
   logic [7:0]       count_q, count_d;
   logic             wdt_expire;

   slurm16_sync2 u_lock_sync (
      .clk (clk),
      .rst (RST),
      .d   (pll_locked),
      .q   (lock_s)
   );

`ifdef SLURM16_RSTSEQ_WDT_EN
   localparam logic [CNT_W-1:0] WdtLast = CNT_W'(WDT_CYCLES - 1);

   logic [CNT_W-1:0] wdt_cnt_q, wdt_cnt_d;

   // Kick on the terminal cycle suppresses expiry.
   assign wdt_expire = (state_q == S_RUN) && !wdt_kick && (wdt_cnt_q == WdtLast);

   // Counter only advances while running; any non-RUN cycle leaves it at zero.
   always_comb begin
      wdt_cnt_d = '0;
      if ((state_q == S_RUN) && !wdt_kick && !wdt_expire) begin
         wdt_cnt_d = wdt_cnt_q + CNT_W'(1);
      end
   end
`else
   logic unused_wdt;

   assign wdt_expire = 1'b0;
   assign unused_wdt = wdt_kick | (WDT_CYCLES == 32'd0);
`endif

   // Next-state logic for the FSM, the shared phase counter and cause/count.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cause_d = cause_q;
      count_d = count_q;
      case (state_q)
         S_RESET: begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
         end
         S_WAIT_LOCK: begin
            cnt_d = '0;
            if (lock_s) state_d = S_STABLE;
         end
         S_STABLE: begin
            if (!lock_s) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == StableLast) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RUN: begin
            cnt_d = '0;
            if (!lock_s) begin
               state_d = S_WAIT_LOCK;
               cause_d = CAUSE_LOCK_LOSS;
               count_d = sat_inc8(count_q);
            end else if (wdt_expire) begin
               state_d = S_HOLD;
               cause_d = CAUSE_WDT;
               count_d = sat_inc8(count_q);
            end else if (soft_reset_req) begin
               state_d = S_HOLD;
               cause_d = CAUSE_SOFT;
               count_d = sat_inc8(count_q);
            end
         end
         S_HOLD: begin
            // Lock loss aborts the hold but the soft/watchdog cause is kept.
            if (!lock_s) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == HoldLast) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_RESET;
            cnt_d   = '0;
         end
      endcase
   end

   // All sequencer state, cleared synchronously by RST.
   always_ff @(posedge clk) begin
      if (RST) begin
         state_q   <= S_RESET;
         cnt_q     <= '0;
         cause_q   <= CAUSE_POR;
         count_q   <= 8'd0;
`ifdef SLURM16_RSTSEQ_WDT_EN
         wdt_cnt_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cause_q   <= cause_d;
         count_q   <= count_d;
`ifdef SLURM16_RSTSEQ_WDT_EN
         wdt_cnt_q <= wdt_cnt_d;
`endif
      end
   end

   assign cpu_RSTb    = (state_q == S_RUN);
   assign state       = state_q;
   assign rst_cause   = cause_q;
   assign reset_count = count_q;

endmodule

// File: tb/tb_slurm16_reset_sequencer.sv
// Scoreboard bench for slurm16_reset_sequencer: random stimulus, a timestamp-based
// reference model pushes expected outputs, a monitor pops and compares each cycle.
module tb_slurm16_reset_sequencer;

   localparam int unsigned LockStable = 8;
   localparam int unsigned Hold       = 4;
   localparam int unsigned Wdt        = 32;
`ifdef SLURM16_RSTSEQ_WDT_EN
   localparam bit WdtEn = 1'b1;
`else
   localparam bit WdtEn = 1'b0;
`endif

   localparam logic [2:0] MReset = 3'd0;
   localparam logic [2:0] MWait  = 3'd1;
   localparam logic [2:0] MStab  = 3'd2;
   localparam logic [2:0] MRun   = 3'd3;
   localparam logic [2:0] MHold  = 3'd4;

   logic       clk = 1'b0;
   logic       RST = 1'b1;
   logic       pll_locked = 1'b0;
   logic       soft_reset_req = 1'b0;
   logic       wdt_kick = 1'b0;
   logic       cpu_RSTb;
   logic [2:0] state;
   logic [1:0] rst_cause;
   logic [7:0] reset_count;

   slurm16_reset_sequencer #(
      .LOCK_STABLE_CYCLES (LockStable),
      .HOLD_CYCLES        (Hold),
      .WDT_CYCLES         (Wdt),
      .CNT_W              (25)
   ) dut (
      .clk            (clk),
      .RST            (RST),
      .pll_locked     (pll_locked),
      .soft_reset_req (soft_reset_req),
      .wdt_kick       (wdt_kick),
      .cpu_RSTb       (cpu_RSTb),
      .state          (state),
      .rst_cause      (rst_cause),
      .reset_count    (reset_count)
   );

   always #5 clk = ~clk;

   // Reference model: phases are timed by edge timestamps, the synchronizer by a
   // two-entry delay queue of pll_locked samples.
   int unsigned t     = 0;
   int unsigned mark  = 0;
   logic [2:0]  m_ph  = MReset;
   logic [1:0]  m_cause = 2'd0;
   logic [7:0]  m_count = 8'd0;
   bit          lock_q[$];

   logic [13:0] exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   function automatic void note_reset(input logic [1:0] c);
      m_cause = c;
      if (m_count != 8'd255) m_count = m_count + 8'd1;
   endfunction

   function automatic void model_edge(input bit r, input bit p, input bit s, input bit k);
      bit ls;
      t = t + 1;
      if (r) begin
         m_ph    = MReset;
         m_cause = 2'd0;
         m_count = 8'd0;
         lock_q  = '{1'b0, 1'b0};
         return;
      end
      ls = lock_q.pop_front();
      lock_q.push_back(p);
      case (m_ph)
         MReset: m_ph = MWait;
         MWait: if (ls) begin m_ph = MStab; mark = t; end
         MStab: begin
            if (!ls) m_ph = MWait;
            else if (t - mark == LockStable) begin m_ph = MRun; mark = t; end
         end
         MRun: begin
            if (!ls) begin note_reset(2'd1); m_ph = MWait; end
            else if (WdtEn && !k && (t - mark == Wdt)) begin
               note_reset(2'd3); m_ph = MHold; mark = t;
            end else if (s) begin note_reset(2'd2); m_ph = MHold; mark = t; end
            else if (WdtEn && k) mark = t;
         end
         MHold: begin
            if (!ls) m_ph = MWait;
            else if (t - mark == Hold) begin m_ph = MRun; mark = t; end
         end
         default: m_ph = MReset;
      endcase
   endfunction

   task automatic drive(input bit r, input bit p, input bit s, input bit k);
      @(negedge clk);
      RST            = r;
      pll_locked     = p;
      soft_reset_req = s;
      wdt_kick       = k;
      model_edge(r, p, s, k);
      exp_q.push_back({(m_ph == MRun), m_ph, m_cause, m_count});
   endtask

   // Monitor: one expected entry per clock edge, compared just after the edge.
   initial begin
      logic [13:0] e;
      logic [13:0] got;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {cpu_RSTb, state, rst_cause, reset_count};
            n_cmp++;
            if (got !== e) begin
               n_bad++;
               $display("FAIL outputs @%0t: got cpu_RSTb=%0b state=%0d cause=%0d count=%0d, want cpu_RSTb=%0b state=%0d cause=%0d count=%0d",
                        $time, got[13], got[12:10], got[9:8], got[7:0],
                        e[13], e[12:10], e[9:8], e[7:0]);
            end
         end
      end
   end

   initial begin
      bit lk;
      bit r;
      lock_q = '{1'b0, 1'b0};

      // Power-on: RST for 3 cycles, then steady lock until the core runs.
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 30; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);

      // General random traffic: lock glitches, soft requests, kicks, rare RST.
      lk = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         if (lk) lk = ($urandom_range(59) != 0);
         else    lk = ($urandom_range(3) == 0);
         r = ($urandom_range(499) == 0);
         drive(r, lk, ($urandom_range(29) == 0), ($urandom_range(24) == 0));
      end

      // Regular kicks every 20 cycles: watchdog must never fire.
      for (int i = 0; i < 400; i++) drive(1'b0, 1'b1, 1'b0, (i % 20) == 19);

      // No kicks: watchdog fires repeatedly when built in.
      for (int i = 0; i < 200; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);

      // Dense soft resets to reach saturation, with occasional lock loss.
      lk = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (lk) lk = ($urandom_range(299) != 0);
         else    lk = ($urandom_range(2) == 0);
         drive(1'b0, lk, ($urandom_range(1) == 1), ($urandom_range(3) == 0));
      end

      for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);

      @(posedge clk);
      #2;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
